vm_change_dispenser: RTL and testbench
======================================

// Module: vm_change_dispenser
// PURPOSE
//  Pays out a refund or change amount requested by the vending-machine controller.
//  Accepts one amount per valid/ready handshake and checks that it can be paid from the coin inventory.
//  Issues 10- and 5-unit coins one at a time to the coin-ejector mechanism (valid/ack), greedy 10s first.
//  Sits between the vending FSM (balance side) and the physical ejector.
// PARAMETERS
//  AMT_W        5   width of requested amount, in money units (max 31)
//  INV_W        4   width of each coin-inventory counter
//  ACK_TIMEOUT  15  cycles coin_valid may stay high without coin_ack before a jam is declared
// PORTS
//  clock        in   1      clock, all logic on rising edge
//  reset        in   1      synchronous, active-high
//  req_valid    in   1      refund request valid
//  req_amount   in   AMT_W  amount to pay out
//  req_ready    out  1      = (state==IDLE && !load); request accepted on req_valid&&req_ready
//  load         in   1      inventory reload strobe, honoured only in IDLE
//  load_n10     in   INV_W  new 10-coin count (replaces, no add)
//  load_n5      in   INV_W  new 5-coin count
//  coin_valid   out  1      coin eject request, held until ack or timeout
//  coin_is10    out  1      1 = 10-unit coin, 0 = 5-unit coin; stable while coin_valid
//  coin_ack     in   1      ejector took the coin; ignored unless coin_valid
//  done         out  1      1-cycle pulse: full amount paid
//  err          out  1      1-cycle pulse: request failed
//  err_code     out  2      0 none, 1 BAD_AMT, 2 NO_CHANGE, 3 JAM; held until next accept
//  inv10, inv5  out  INV_W  current inventory
// BEHAVIOUR
//  Reset: state IDLE; coin_valid, coin_is10, done, err, err_code, inv10, inv5, counters all 0.
//   Reset mid-payout aborts immediately; no done/err pulse.
//  States: IDLE -> CHECK -> {DISPENSE <-> GAP} -> DONE | ERR -> IDLE.
//  IDLE: load=1 writes inv10/inv5 and wins over a simultaneous req_valid (req_ready=0 that cycle).
//   On accept, latch amount, clear err_code, go to CHECK.
//  CHECK (1 cycle): n10 = min(amt/10, inv10); rem = amt - 10*n10.
//   amt%5 != 0 -> ERR code 1.
//   Else rem/5 > inv5 -> ERR code 2.
//   Else cnt10=n10, cnt5=rem/5.
//   amt==0 -> DONE with no coins; otherwise -> DISPENSE.
//   Infeasible requests eject nothing and leave the inventory unchanged.
//  DISPENSE: coin_valid=1, coin_is10=(cnt10!=0).
//   First coin_valid occurs 2 cycles after the accept edge.
//   Edge with coin_ack=1: decrement cnt and matching inv; coin_valid drops.
//   Go to GAP if coins remain, else DONE.
//  GAP: exactly 1 cycle with coin_valid=0 (ejector recovery), then DISPENSE.
//  Timeout: cycle counter cleared on DISPENSE entry.
//   ACK_TIMEOUT cycles without ack -> ERR code 3; coin_valid drops.
//   That coin is not decremented; the remaining coins are abandoned.
//  DONE / ERR: single-cycle states that assert done / err for that cycle, then IDLE.
//  All arithmetic is unsigned. Inventory never wraps: a decrement only happens for a coin proven available in CHECK.
// STRUCTURE
//  Shared package vm_pkg:
//   - money constants MONEY_5=5, MONEY_10=10, MONEY_20=20 (common with the vending FSM)
//   - state enum dispenser_state_t
//   - err_code constants
//  One sub-module vm_coin_plan: combinational CHECK math (amount, inv10, inv5 -> n10, n5, ok, code).
//  FSM, counters and inventory stay in this module.
// TESTING
//  1. inv10=3, inv5=3; req 25 -> coins 10, 10, 5; done; inv10=1, inv5=2.
//  2. inv10=0, inv5=2; req 15 -> err code 2; no coin_valid; inventory unchanged.
//  3. req 7 -> err code 1. req 0 -> done 2 cycles after accept, no coins.
//  4. inv10=1, inv5=4; req 30 -> 10, 5, 5, 5, 5.
//     Ack delayed 3 cycles on the 2nd coin -> coin_valid and coin_is10 held stable.
//     Exactly 1 GAP cycle between coins.
//  5. Never ack -> err code 3 after 15 cycles; inventory decremented only for acked coins.
//  6. load+req_valid in the same IDLE cycle -> load wins, request taken next cycle.
//     reset during DISPENSE -> all outputs 0 next cycle.

Source files
------------

// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared vending-machine constants, dispenser states and error codes
package vm_pkg;

    // Money units shared with the vending FSM
    localparam int unsigned MONEY_5  = 5;
    localparam int unsigned MONEY_10 = 10;
    localparam int unsigned MONEY_20 = 20;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_GAP      = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERR      = 3'd5
    } dispenser_state_t;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_BAD_AMT   = 2'd1;
    localparam logic [1:0] ERR_NO_CHANGE = 2'd2;
    localparam logic [1:0] ERR_JAM       = 2'd3;

endpackage

// File: rtl/vm_coin_plan.sv
// rtl/vm_coin_plan.sv - combinational greedy coin plan for a payout amount
//
// Ports:
//   amount  in   AMT_W  amount to pay
//   inv10   in   INV_W  available 10-unit coins
//   inv5    in   INV_W  available 5-unit coins
//   n10     out  INV_W  10-unit coins to eject (0 when not ok)
//   n5      out  INV_W  5-unit coins to eject (0 when not ok)
//   ok      out  1      amount payable from inventory
//   code    out  2      failure reason when !ok
module vm_coin_plan
    import vm_pkg::*;
#(
    parameter int AMT_W = 5,
    parameter int INV_W = 4
) (
    input  logic [AMT_W-1:0] amount,
    input  logic [INV_W-1:0] inv10,
    input  logic [INV_W-1:0] inv5,
    output logic [INV_W-1:0] n10,
    output logic [INV_W-1:0] n5,
    output logic             ok,
    output logic [1:0]       code
);

    // Wide enough for both operands plus the 10*n10 product, which never exceeds amount
    localparam int CW = ((AMT_W > INV_W) ? AMT_W : INV_W) + 4;

    logic [CW-1:0] amt_w;
    logic [CW-1:0] inv10_w;
    logic [CW-1:0] inv5_w;
    logic [CW-1:0] q10;
    logic [CW-1:0] n10_w;
    logic [CW-1:0] rem_w;
    logic [CW-1:0] q5;

    always_comb begin
        amt_w   = CW'(amount);
        inv10_w = CW'(inv10);
        inv5_w  = CW'(inv5);
        q10     = amt_w / CW'(MONEY_10);
        // Greedy: as many 10s as the inventory allows, remainder in 5s
        n10_w   = (q10 < inv10_w) ? q10 : inv10_w;
        rem_w   = amt_w - n10_w * CW'(MONEY_10);
        q5      = rem_w / CW'(MONEY_5);

        ok   = 1'b1;
        code = ERR_NONE;
        if ((amt_w % CW'(MONEY_5)) != '0) begin
            ok   = 1'b0;
            code = ERR_BAD_AMT;
        end else if (q5 > inv5_w) begin
            ok   = 1'b0;
            code = ERR_NO_CHANGE;
        end

        n10 = ok ? INV_W'(n10_w) : '0;
        n5  = ok ? INV_W'(q5)    : '0;
    end

endmodule

// File: rtl/vm_change_dispenser.sv
// rtl/vm_change_dispenser.sv - pays out refund/change as 10- and 5-unit coins
//
// Ports:
//   clock, reset           clock; synchronous active-high reset
//   req_valid/req_amount   payout request (handshake with req_ready)
//   req_ready              IDLE and no reload this cycle
//   load/load_n10/load_n5  inventory reload, honoured only in IDLE
//   coin_valid/coin_is10   coin eject request to the ejector, held until coin_ack or timeout
//   coin_ack               ejector took the coin
//   done / err             1-cycle completion / failure pulses
//   err_code               failure reason, held until the next accepted request
//   inv10 / inv5           current coin inventory
module vm_change_dispenser
    import vm_pkg::*;
#(
    parameter int AMT_W       = 5,
    parameter int INV_W       = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             load,
    input  logic [INV_W-1:0] load_n10,
    input  logic [INV_W-1:0] load_n5,
    output logic             coin_valid,
    output logic             coin_is10,
    input  logic             coin_ack,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [INV_W-1:0] inv10,
    output logic [INV_W-1:0] inv5
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    dispenser_state_t state, state_next;

    logic [AMT_W-1:0] amt;
    logic [INV_W-1:0] cnt10;
    logic [INV_W-1:0] cnt5;
    logic [TW-1:0]    tmo_cnt;

    logic [INV_W-1:0] plan_n10;
    logic [INV_W-1:0] plan_n5;
    logic             plan_ok;
    logic [1:0]       plan_code;

    logic last_coin;
    logic tmo_hit;

    vm_coin_plan #(
        .AMT_W (AMT_W),
        .INV_W (INV_W)
    ) u_plan (
        .amount (amt),
        .inv10  (inv10),
        .inv5   (inv5),
        .n10    (plan_n10),
        .n5     (plan_n5),
        .ok     (plan_ok),
        .code   (plan_code)
    );

    // The coin currently offered is the only one left
    assign last_coin = ((cnt10 == INV_W'(1)) && (cnt5 == '0)) ||
                       ((cnt10 == '0) && (cnt5 == INV_W'(1)));
    // Last cycle of the ack window; an ack arriving in this cycle still counts
    assign tmo_hit   = (tmo_cnt == TW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        coin_valid = 1'b0;
        coin_is10  = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = !load;
                if (!load && req_valid) state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (!plan_ok)                                  state_next = ST_ERR;
                else if ((plan_n10 == '0) && (plan_n5 == '0)) state_next = ST_DONE;
                else                                           state_next = ST_DISPENSE;
            end
            ST_DISPENSE: begin
                coin_valid = 1'b1;
                coin_is10  = (cnt10 != '0);
                if (coin_ack)     state_next = last_coin ? ST_DONE : ST_GAP;
                else if (tmo_hit) state_next = ST_ERR;
            end
            ST_GAP:  state_next = ST_DISPENSE;
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            ST_ERR: begin
                err        = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            amt      <= '0;
            cnt10    <= '0;
            cnt5     <= '0;
            tmo_cnt  <= '0;
            err_code <= ERR_NONE;
            inv10    <= '0;
            inv5     <= '0;
        end else begin
            // Outside DISPENSE the counter sits at zero, so each coin starts a fresh window
            if (state != ST_DISPENSE) tmo_cnt <= '0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        inv10 <= load_n10;
                        inv5  <= load_n5;
                    end else if (req_valid) begin
                        amt      <= req_amount;
                        err_code <= ERR_NONE;
                    end
                end
                ST_CHECK: begin
                    if (plan_ok) begin
                        cnt10 <= plan_n10;
                        cnt5  <= plan_n5;
                    end else begin
                        err_code <= plan_code;
                    end
                end
                ST_DISPENSE: begin
                    if (coin_ack) begin
                        tmo_cnt <= '0;
                        if (cnt10 != '0) begin
                            cnt10 <= cnt10 - INV_W'(1);
                            inv10 <= inv10 - INV_W'(1);
                        end else begin
                            cnt5 <= cnt5 - INV_W'(1);
                            inv5 <= inv5 - INV_W'(1);
                        end
                    end else if (tmo_hit) begin
                        err_code <= ERR_JAM;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// tb/tb_vm_change_dispenser.sv - scoreboard bench for vm_change_dispenser
module tb_vm_change_dispenser;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [4:0] req_amount;
    logic       req_ready;
    logic       load;
    logic [3:0] load_n10;
    logic [3:0] load_n5;
    logic       coin_valid;
    logic       coin_is10;
    logic       coin_ack;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic [3:0] inv10;
    logic [3:0] inv5;

    int total = 0;
    int bad   = 0;

    // Event encoding: {kind, value}; kind 0 = coin (value = is10), 1 = done, 2 = err (value = code)
    logic [3:0] exp_q[$];
    int         delay_q[$];

    vm_change_dispenser #(.AMT_W(5), .INV_W(4), .ACK_TIMEOUT(15)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_amount (req_amount),
        .req_ready  (req_ready),
        .load       (load),
        .load_n10   (load_n10),
        .load_n5    (load_n5),
        .coin_valid (coin_valid),
        .coin_is10  (coin_is10),
        .coin_ack   (coin_ack),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .inv10      (inv10),
        .inv5       (inv5)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] ev_coin(input logic is10);
        return {2'd0, 1'b0, is10};
    endfunction
    function automatic logic [3:0] ev_done();
        return {2'd1, 2'd0};
    endfunction
    function automatic logic [3:0] ev_err(input logic [1:0] code);
        return {2'd2, code};
    endfunction

    // Ejector model: per-coin ack delay taken from delay_q (0 when empty)
    int  cur_delay = 0;
    int  wait_cnt  = 0;
    bit  busy      = 0;
    always @(posedge clock) begin
        #1;
        if (coin_ack) begin
            coin_ack = 1'b0;
        end else if (coin_valid) begin
            if (!busy) begin
                cur_delay = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
                busy      = 1;
                wait_cnt  = 0;
            end
            if (wait_cnt == cur_delay) begin
                coin_ack = 1'b1;
                busy     = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            busy = 0;
        end
    end

    // Monitor: scoreboard compare plus hold-stability, gap-length and timeout-length checks
    logic       prev_valid = 1'b0;
    logic       prev_is10  = 1'b0;
    logic       prev_ack   = 1'b0;
    bit         after_ack  = 0;
    int         gap_len    = 0;
    int         run_len    = 0;
    int         last_run   = 0;
    logic [3:0] ev;
    logic [3:0] expv;
    always @(negedge clock) begin
        if (reset) begin
            after_ack  = 0;
            prev_valid = 1'b0;
            prev_ack   = 1'b0;
            run_len    = 0;
        end else begin
            if (coin_valid) begin
                if (prev_valid && !prev_ack)
                    check("coin_is10 stable while held", int'(coin_is10), int'(prev_is10));
                if (!prev_valid && after_ack) begin
                    check("gap cycles between coins", gap_len, 1);
                    after_ack = 0;
                end
                run_len++;
            end else begin
                if (prev_valid) last_run = run_len;
                run_len = 0;
                gap_len++;
            end

            if (coin_valid || done || err) begin
                ev = 4'hF;
                if (coin_valid && coin_ack) begin
                    ev        = ev_coin(coin_is10);
                    after_ack = 1;
                    gap_len   = 0;
                end else if (done) begin
                    ev        = ev_done();
                    after_ack = 0;
                end else if (err) begin
                    ev        = ev_err(err_code);
                    after_ack = 0;
                    if (err_code == 2'd3) check("jam after held cycles", last_run, 15);
                end
                if (ev != 4'hF) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected event", int'(ev), -1);
                    end else begin
                        expv = exp_q.pop_front();
                        check("scoreboard event", int'(ev), int'(expv));
                    end
                end
            end
            prev_valid = coin_valid;
            prev_is10  = coin_is10;
            prev_ack   = coin_ack;
        end
    end

    task automatic do_load(input logic [3:0] n10, input logic [3:0] n5);
        load     = 1'b1;
        load_n10 = n10;
        load_n5  = n5;
        @(posedge clock); #1;
        load = 1'b0;
    endtask

    // Returns one time unit after the accepting clock edge
    task automatic send_req(input logic [4:0] amt);
        int n = 0;
        req_valid  = 1'b1;
        req_amount = amt;
        #1;
        while (!req_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (!req_ready) check("req_ready timeout", 0, 1);
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        check("return to idle", int'(req_ready), 1);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_amount = '0;
        load       = 1'b0;
        load_n10   = '0;
        load_n5    = '0;
        coin_ack   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset coin_valid", int'(coin_valid), 0);
        check("reset err_code", int'(err_code), 0);
        check("reset inv10", int'(inv10), 0);
        check("reset inv5", int'(inv5), 0);
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle req_ready", int'(req_ready), 1);

        // 1: 25 from 3x10 + 3x5 -> 10, 10, 5
        do_load(4'd3, 4'd3);
        exp_q.push_back(ev_coin(1'b1));
        exp_q.push_back(ev_coin(1'b1));
        exp_q.push_back(ev_coin(1'b0));
        exp_q.push_back(ev_done());
        send_req(5'd25);
        check("t1 no coin in CHECK", int'(coin_valid), 0);
        @(posedge clock); #1;
        check("t1 coin_valid 2 cycles after accept", int'(coin_valid), 1);
        wait_idle();
        check("t1 inv10", int'(inv10), 1);
        check("t1 inv5", int'(inv5), 2);

        // 2: 15 with no 10s and only two 5s -> NO_CHANGE
        do_load(4'd0, 4'd2);
        exp_q.push_back(ev_err(2'd2));
        send_req(5'd15);
        wait_idle();
        check("t2 err_code held", int'(err_code), 2);
        check("t2 inv10 unchanged", int'(inv10), 0);
        check("t2 inv5 unchanged", int'(inv5), 2);

        // 3: 7 -> BAD_AMT; 0 -> done with no coins
        exp_q.push_back(ev_err(2'd1));
        send_req(5'd7);
        wait_idle();
        check("t3 err_code bad amount", int'(err_code), 1);
        exp_q.push_back(ev_done());
        send_req(5'd0);
        check("t3 done not in CHECK", int'(done), 0);
        check("t3 err_code cleared on accept", int'(err_code), 0);
        @(posedge clock); #1;
        check("t3 done 2 cycles after accept", int'(done), 1);
        wait_idle();

        // 4: 30 from 1x10 + 4x5, second coin acked late
        do_load(4'd1, 4'd4);
        delay_q = {0, 3, 0, 0, 0};
        exp_q.push_back(ev_coin(1'b1));
        repeat (4) exp_q.push_back(ev_coin(1'b0));
        exp_q.push_back(ev_done());
        send_req(5'd30);
        wait_idle();
        check("t4 inv10", int'(inv10), 0);
        check("t4 inv5", int'(inv5), 0);

        // 5: first coin acked, second never acked -> JAM
        do_load(4'd2, 4'd2);
        delay_q = {0, 100};
        exp_q.push_back(ev_coin(1'b1));
        exp_q.push_back(ev_err(2'd3));
        send_req(5'd20);
        wait_idle();
        check("t5 err_code jam", int'(err_code), 3);
        check("t5 inv10 only acked coin", int'(inv10), 1);
        check("t5 inv5", int'(inv5), 2);

        // 6: load and request in the same cycle -> load first, request next cycle
        load       = 1'b1;
        load_n10   = 4'd1;
        load_n5    = 4'd1;
        req_valid  = 1'b1;
        req_amount = 5'd15;
        #1;
        check("t6 req_ready low during load", int'(req_ready), 0);
        @(posedge clock); #1;
        load = 1'b0;
        check("t6 inv10 loaded", int'(inv10), 1);
        exp_q.push_back(ev_coin(1'b1));
        exp_q.push_back(ev_coin(1'b0));
        exp_q.push_back(ev_done());
        send_req(5'd15);
        wait_idle();
        check("t6 inv10", int'(inv10), 0);
        check("t6 inv5", int'(inv5), 0);

        // Reset while a coin is being offered
        do_load(4'd2, 4'd0);
        delay_q = {100};
        send_req(5'd20);
        @(posedge clock); #1;
        check("t7 coin_valid before reset", int'(coin_valid), 1);
        reset = 1'b1;
        @(posedge clock); #1;
        check("t7 coin_valid after reset", int'(coin_valid), 0);
        check("t7 coin_is10 after reset", int'(coin_is10), 0);
        check("t7 done after reset", int'(done), 0);
        check("t7 err after reset", int'(err), 0);
        check("t7 inv10 after reset", int'(inv10), 0);
        reset = 1'b0;
        delay_q = {};
        repeat (3) @(posedge clock);
        #1;
        check("t7 idle after reset", int'(req_ready), 1);
        check("scoreboard drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
